// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (types only).
// Backpressure: n/a.
package fetch_pkg;

  // Fetch controller states; HALT is only reachable with alignment checking built in.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Bytes per instruction word; the PC advances by this much per issued read.
  localparam int INSTR_BYTES = 4;

  // Default bus widths.
  localparam int INS_W  = 32;
  localparam int ADDR_W = 32;

  // One buffered instruction with the address it was fetched from.
  typedef struct packed {
    logic [INS_W-1:0]  ins;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  // True when an address lands on an instruction-word boundary.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction fetch bus: imem request/response, decode handshake and redirect.
// Latency: n/a (wiring only).
// Backpressure: ins_ready stalls the decode side; imem has no backpressure.
interface instr_fetch_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  imem_en;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0]      imem_rdata;
  logic [WIDTH-1:0]      ins;
  logic [ADDR_WIDTH-1:0] ins_pc;
  logic                  ins_valid;
  logic                  ins_ready;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  fetch_fault;

  // Fetch unit side.
  modport master (
    output imem_en, imem_addr, ins, ins_pc, ins_valid, fetch_fault,
    input  imem_rdata, ins_ready, branch_taken, branch_target
  );

  // Memory / decode / execute side.
  modport slave (
    input  imem_en, imem_addr, ins, ins_pc, ins_valid, fetch_fault,
    output imem_rdata, ins_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO with push/pop/clear and an occupancy count.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: caller must not push when full; pops on empty are ignored.
module fetch_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  input  logic          clear,
  output logic [DW-1:0] head_dat,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && (count != CW'(DEPTH));
  assign do_pop   = pop && (count != '0);
  assign head_dat = mem[rd_ptr];

  // Storage, pointers and count; clear empties the queue without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads imem sequentially, buffers words for decode.
// Latency: first ins_valid 2 cycles after reset release; redirect target valid 3 cycles after branch.
// Backpressure: reads issue only when buffer space is guaranteed, so no response is ever dropped.
// Build option: INSTR_FETCH_ALIGN_CHECK_EN traps misaligned branch targets into a sticky fault.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                    WIDTH      = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  instr_fetch_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = WIDTH + ADDR_WIDTH;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic [CW-1:0]         count;
  logic [EW-1:0]         head;
  logic [CW:0]           occ;
  logic                  active;
  logic                  redirect;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  misaligned;
  logic [ADDR_WIDTH-1:0] target;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
  logic fault;

  assign target     = bus.branch_target;
  assign misaligned = bus.branch_taken && !is_word_aligned(bus.branch_target[1:0]);

  // Sticky fault: set by a misaligned redirect, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    fault <= 1'b0;
    else if (redirect && misaligned) fault <= 1'b1;
  end

  assign bus.fetch_fault = fault;
`else
  logic unused_target_lsb;

  // Without the check, low target bits are simply dropped to keep the PC word aligned.
  assign unused_target_lsb = ^bus.branch_target[1:0];
  assign target            = {bus.branch_target[ADDR_WIDTH-1:2], 2'b00};
  assign misaligned        = 1'b0;
  assign bus.fetch_fault   = 1'b0;
`endif

  assign active   = (state != HALT);
  assign redirect = active && bus.branch_taken;
  assign pop      = bus.ins_valid && bus.ins_ready;

  // Occupancy once this cycle's pop and the outstanding response are accounted for.
  assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue = rst_n && active && !bus.branch_taken && (occ < DEPTH_L);

  // A redirect drops the response landing this cycle along with the buffered wrong path.
  assign push = inflight && !redirect;

  assign bus.imem_en   = issue;
  assign bus.imem_addr = pc;
  assign bus.ins       = head[EW-1:ADDR_WIDTH];
  assign bus.ins_pc    = head[ADDR_WIDTH-1:0];
  assign bus.ins_valid = active && (count != '0);

  fetch_fifo #(
    .DW    (EW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat ({bus.imem_rdata, inflight_pc}),
    .pop      (pop),
    .clear    (redirect),
    .head_dat (head),
    .count    (count)
  );

  // Fetch controller: PC, outstanding-read tracking and state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      case (state)
        BOOT, RUN: begin
          if (redirect) begin
            inflight <= 1'b0;
            pc       <= target;
            state    <= misaligned ? HALT : RUN;
          end else begin
            state    <= RUN;
            inflight <= issue;
            if (issue) begin
              inflight_pc <= pc;
              pc          <= pc + ADDR_WIDTH'(INSTR_BYTES);
            end
          end
        end
        HALT: begin
          inflight <= 1'b0;
        end
        default: begin
          state    <= BOOT;
          inflight <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch with a 1-cycle synchronous imem model.
module tb_instr_fetch;
  import fetch_pkg::*;

  typedef struct {
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        en;
    logic [31:0] addr;
    logic        chk_addr;
    logic        vld;
    logic [31:0] pc;
    logic        fault;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[24];
  vec_t wrap[6];

  always #5 clk = ~clk;

  instr_fetch_if #(.WIDTH(32), .ADDR_WIDTH(32)) bus ();

  instr_fetch #(
    .WIDTH      (32),
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h5A5A_0000;
  endfunction

  // Synchronous instruction memory: data one cycle after the request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           bus.imem_rdata <= '0;
    else if (bus.imem_en) bus.imem_rdata <= memf(bus.imem_addr);
  end

  function automatic vec_t mk(input logic rdy, input logic br, input logic [31:0] tgt,
                              input logic en, input logic [31:0] addr, input logic chk_addr,
                              input logic vld, input logic [31:0] pc, input logic fault);
    vec_t v;
    v.rdy = rdy; v.br = br; v.tgt = tgt; v.en = en; v.addr = addr;
    v.chk_addr = chk_addr; v.vld = vld; v.pc = pc; v.fault = fault;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, let outputs settle, compare, move to next falling edge.
  task automatic apply(input vec_t v, input string tag, input int idx);
    bus.ins_ready     = v.rdy;
    bus.branch_taken  = v.br;
    bus.branch_target = v.tgt;
    #1;
    chk($sformatf("%s%0d.imem_en", tag, idx), 32'(bus.imem_en), 32'(v.en));
    if (v.chk_addr) chk($sformatf("%s%0d.imem_addr", tag, idx), bus.imem_addr, v.addr);
    chk($sformatf("%s%0d.ins_valid", tag, idx), 32'(bus.ins_valid), 32'(v.vld));
    if (v.vld) begin
      chk($sformatf("%s%0d.ins_pc", tag, idx), bus.ins_pc, v.pc);
      chk($sformatf("%s%0d.ins", tag, idx), bus.ins, memf(v.pc));
    end
    chk($sformatf("%s%0d.fetch_fault", tag, idx), 32'(bus.fetch_fault), 32'(v.fault));
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".imem_en"},     32'(bus.imem_en),     32'd0);
    chk({tag, ".imem_addr"},   bus.imem_addr,        32'h0);
    chk({tag, ".ins_valid"},   32'(bus.ins_valid),   32'd0);
    chk({tag, ".ins"},         bus.ins,              32'h0);
    chk({tag, ".ins_pc"},      bus.ins_pc,           32'h0);
    chk({tag, ".fetch_fault"}, 32'(bus.fetch_fault), 32'd0);
  endtask

  initial begin
    //             rdy br tgt           en addr          ca vld pc            flt
    vecs[0]  = mk(1, 0, 32'h0,        1, 32'h00,      1, 0, 32'h0,        0); // boot read
    vecs[1]  = mk(1, 0, 32'h0,        1, 32'h04,      1, 0, 32'h0,        0);
    vecs[2]  = mk(1, 0, 32'h0,        1, 32'h08,      1, 1, 32'h00,       0); // first valid
    vecs[3]  = mk(1, 0, 32'h0,        1, 32'h0C,      1, 1, 32'h04,       0);
    vecs[4]  = mk(1, 0, 32'h0,        1, 32'h10,      1, 1, 32'h08,       0);
    vecs[5]  = mk(0, 0, 32'h0,        0, 32'h14,      1, 1, 32'h0C,       0); // stall begins
    vecs[6]  = mk(0, 0, 32'h0,        0, 32'h14,      1, 1, 32'h0C,       0); // 2 buffered
    vecs[7]  = mk(0, 0, 32'h0,        0, 32'h14,      1, 1, 32'h0C,       0);
    vecs[8]  = mk(0, 0, 32'h0,        0, 32'h14,      1, 1, 32'h0C,       0);
    vecs[9]  = mk(0, 0, 32'h0,        0, 32'h14,      1, 1, 32'h0C,       0);
    vecs[10] = mk(1, 0, 32'h0,        1, 32'h14,      1, 1, 32'h0C,       0); // release
    vecs[11] = mk(1, 0, 32'h0,        1, 32'h18,      1, 1, 32'h10,       0);
    vecs[12] = mk(1, 0, 32'h0,        1, 32'h1C,      1, 1, 32'h14,       0);
    vecs[13] = mk(0, 1, 32'h40,       0, 32'h20,      1, 1, 32'h18,       0); // branch, 1 buffered + 1 in flight
    vecs[14] = mk(1, 0, 32'h0,        1, 32'h40,      1, 0, 32'h0,        0);
    vecs[15] = mk(1, 0, 32'h0,        1, 32'h44,      1, 0, 32'h0,        0);
    vecs[16] = mk(1, 0, 32'h0,        1, 32'h48,      1, 1, 32'h40,       0); // target at N+3
    vecs[17] = mk(1, 1, 32'h80,       0, 32'h4C,      1, 1, 32'h44,       0); // branch with handshake
    vecs[18] = mk(1, 0, 32'h0,        1, 32'h80,      1, 0, 32'h0,        0);
    vecs[19] = mk(1, 0, 32'h0,        1, 32'h84,      1, 0, 32'h0,        0);
    vecs[20] = mk(1, 1, 32'h42,       0, 32'h88,      1, 1, 32'h80,       0); // misaligned target
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    vecs[21] = mk(1, 0, 32'h0,        0, 32'h0,       0, 0, 32'h0,        1);
    vecs[22] = mk(1, 0, 32'h0,        0, 32'h0,       0, 0, 32'h0,        1);
    vecs[23] = mk(1, 0, 32'h0,        0, 32'h0,       0, 0, 32'h0,        1);
`else
    vecs[21] = mk(1, 0, 32'h0,        1, 32'h40,      1, 0, 32'h0,        0);
    vecs[22] = mk(1, 0, 32'h0,        1, 32'h44,      1, 0, 32'h0,        0);
    vecs[23] = mk(1, 0, 32'h0,        1, 32'h48,      1, 1, 32'h40,       0);
`endif
    // After a mid-run reset: redirect to the last word, then wrap to 0.
    wrap[0]  = mk(1, 0, 32'h0,        1, 32'h0,       1, 0, 32'h0,        0);
    wrap[1]  = mk(1, 1, 32'hFFFF_FFFC, 0, 32'h4,      1, 0, 32'h0,        0);
    wrap[2]  = mk(1, 0, 32'h0,        1, 32'hFFFF_FFFC, 1, 0, 32'h0,      0);
    wrap[3]  = mk(1, 0, 32'h0,        1, 32'h0,       1, 0, 32'h0,        0);
    wrap[4]  = mk(1, 0, 32'h0,        1, 32'h4,       1, 1, 32'hFFFF_FFFC, 0);
    wrap[5]  = mk(1, 0, 32'h0,        1, 32'h8,       1, 1, 32'h0,        0);

    bus.ins_ready     = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;

    #1 rst_n = 1'b0;
    #15;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) apply(vecs[i], "main", i);

    // Asynchronous reset in the middle of activity.
    rst_n = 1'b0;
    bus.branch_taken = 1'b0;
    #1;
    chk_reset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) apply(wrap[i], "wrap", i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
